// File: rtl/slc3_input_pkg.sv
// slc3_input_pkg: shared debouncer state encoding and button indices for the input conditioner
package slc3_input_pkg;
    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} db_state_t;
    localparam int BTN_RESET = 0, BTN_RUN = 1, BTN_CONTINUE = 2, NUM_BTN = 3;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: accepts a synchronized active-low key level only after it holds steady, with a press strobe
module button_debouncer
    import slc3_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic key_sync,
    output logic level_n,
    output logic press_pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);
    db_state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic down;
    assign down = (state == PRESSED) || (state == RELEASE_WAIT);
    // State and counter registers; level and strobe are registered one edge behind the state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= RELEASED;
            cnt         <= '0;
            level_n     <= 1'b1;
            press_pulse <= 1'b0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            level_n     <= !down;
            press_pulse <= level_n && down;
        end
    end
    // Next state: a change must persist for DEBOUNCE_CYCLES+1 samples; any glitch restarts the count
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            RELEASED: begin
                state_nx = key_sync ? RELEASED : PRESS_WAIT;
                cnt_nx   = key_sync ? '0 : CW'(1);
            end
            PRESS_WAIT: begin
                if (key_sync) begin
                    state_nx = RELEASED;
                    cnt_nx   = '0;
                end else if (cnt == CMAX) state_nx = PRESSED;
                else cnt_nx = cnt + 1'b1;
            end
            PRESSED: begin
                state_nx = key_sync ? RELEASE_WAIT : PRESSED;
                cnt_nx   = key_sync ? CW'(1) : '0;
            end
            RELEASE_WAIT: begin
                if (!key_sync) begin
                    state_nx = PRESSED;
                    cnt_nx   = '0;
                end else if (cnt == CMAX) state_nx = RELEASED;
                else cnt_nx = cnt + 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/slc3_input_conditioner.sv
// slc3_input_conditioner: synchronizes switches and synchronizes/debounces the three board buttons
module slc3_input_conditioner
    import slc3_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int SW_WIDTH        = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [NUM_BTN-1:0]  KEY_raw,
    input  logic [SW_WIDTH-1:0] SW_raw,
    output logic                RESET_n,
    output logic                RUN_n,
    output logic                CONTINUE_n,
    output logic [NUM_BTN-1:0]  press_pulse,
    output logic [SW_WIDTH-1:0] S
);
    logic [SYNC_STAGES-1:0][NUM_BTN-1:0]  key_sq;
    logic [SYNC_STAGES-1:0][SW_WIDTH-1:0] sw_sq;
    logic [NUM_BTN-1:0] key_sync, level_n;
    assign key_sync = key_sq[SYNC_STAGES-1];
    // Synchronizer chains (keys idle released, switches idle low) plus the switch output register
    always_ff @(posedge Clk) begin
        key_sq <= Reset ? '1 : {key_sq[SYNC_STAGES-2:0], KEY_raw};
        sw_sq  <= Reset ? '0 : {sw_sq[SYNC_STAGES-2:0], SW_raw};
        S      <= Reset ? '0 : sw_sq[SYNC_STAGES-1];
    end
    for (genvar b = 0; b < NUM_BTN; b++) begin : g_db
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .Clk        (Clk),
            .Reset      (Reset),
            .key_sync   (key_sync[b]),
            .level_n    (level_n[b]),
            .press_pulse(press_pulse[b])
        );
    end
    assign RESET_n    = level_n[BTN_RESET];
    assign RUN_n      = level_n[BTN_RUN];
    assign CONTINUE_n = level_n[BTN_CONTINUE];
endmodule
